// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: runs one SPI frame per request through an AXI-lite SPI
// controller (clear events, command, tx word, poll DON, optional rx read).
module spi_xfer_sequencer #(
    parameter logic [7:0]  ADDR_SPIE  = 8'h04,
    parameter logic [7:0]  ADDR_SPCOM = 8'h08,
    parameter logic [7:0]  ADDR_SPITF = 8'h0C,
    parameter logic [7:0]  ADDR_SPIRF = 8'h10,
    parameter int unsigned POLL_MAX   = 1024
) (
    input  logic        S_SYSCLK,
    input  logic        S_RESETN,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_SPCOM,
    input  logic [31:0] REQ_TXDATA,
    input  logic        REQ_RXEN,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RXDATA,
    output logic        RSP_ERR,
    output logic [7:0]  M_AWADDR,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [7:0]  M_ARADDR,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    localparam int unsigned CW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLR, WCOM, WTX, POLL, RDRF, RESP} state_t;

    state_t        state_q, state_d, wr_next;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0]   spcom_q, spcom_d, txdata_q, txdata_d, rxdata_q, rxdata_d;
    logic          rxen_q, rxen_d, err_q, err_d;
    logic [CW-1:0] poll_q, poll_d;
    logic [7:0]    wr_addr, rd_addr;
    logic [31:0]   wr_data;

    always_comb begin
        wr_addr = ADDR_SPITF;
        wr_data = txdata_q;
        wr_next = POLL;
        case (state_q)
            CLR:     begin wr_addr = ADDR_SPIE;  wr_data = '1;      wr_next = WCOM; end
            WCOM:    begin wr_addr = ADDR_SPCOM; wr_data = spcom_q; wr_next = WTX;  end
            default: ;
        endcase
        rd_addr = (state_q == POLL) ? ADDR_SPIE : ADDR_SPIRF;
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        spcom_d   = spcom_q;
        txdata_d  = txdata_q;
        rxen_d    = rxen_q;
        rxdata_d  = rxdata_q;
        err_d     = err_q;
        poll_d    = poll_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    spcom_d   = REQ_SPCOM;
                    txdata_d  = REQ_TXDATA;
                    rxen_d    = REQ_RXEN;
                    rxdata_d  = '0;
                    err_d     = 1'b0;
                    poll_d    = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = CLR;
                end
            end
            CLR, WCOM, WTX: begin
                if (awvalid_q && M_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d && !bready_q) bready_d = 1'b1;
                // The next transaction is launched on the same edge that completes B.
                if (bready_q && M_BVALID) begin
                    bready_d = 1'b0;
                    state_d  = wr_next;
                    if (state_q == WTX) begin
                        arvalid_d = 1'b1;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            POLL, RDRF: begin
                if (arvalid_q && M_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (rready_q && M_RVALID) begin
                    rready_d = 1'b0;
                    if (state_q == RDRF) rxdata_d = M_RDATA;
                    if (M_RRESP != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (state_q == RDRF) begin
                        state_d = RESP;
                    end else if (M_RDATA[8]) begin
                        if (rxen_q) begin
                            state_d   = RDRF;
                            arvalid_d = 1'b1;
                        end else begin
                            state_d = RESP;
                        end
                    end else if (poll_q == CW'(POLL_MAX - 1)) begin
                        poll_d  = poll_q + 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        poll_d    = poll_q + 1'b1;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            spcom_q   <= '0;
            txdata_q  <= '0;
            rxen_q    <= 1'b0;
            rxdata_q  <= '0;
            err_q     <= 1'b0;
            poll_q    <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            spcom_q   <= spcom_d;
            txdata_q  <= txdata_d;
            rxen_q    <= rxen_d;
            rxdata_q  <= rxdata_d;
            err_q     <= err_d;
            poll_q    <= poll_d;
        end
    end

    assign REQ_READY  = (state_q == IDLE);
    assign RSP_VALID  = (state_q == RESP);
    assign RSP_RXDATA = rxdata_q;
    assign RSP_ERR    = err_q;
    assign M_AWVALID  = awvalid_q;
    assign M_AWADDR   = awvalid_q ? wr_addr : '0;
    assign M_WVALID   = wvalid_q;
    assign M_WDATA    = wvalid_q ? wr_data : '0;
    assign M_WSTRB    = wvalid_q ? 4'hF : 4'h0;
    assign M_BREADY   = bready_q;
    assign M_ARVALID  = arvalid_q;
    assign M_ARADDR   = arvalid_q ? rd_addr : '0;
    assign M_RREADY   = rready_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: AXI-lite SPI controller model on
// the negative edge, expected transactions queued per request and compared.
module tb_spi_xfer_sequencer;

    localparam logic [7:0]  A_SPIE  = 8'h04;
    localparam logic [7:0]  A_SPCOM = 8'h08;
    localparam logic [7:0]  A_SPITF = 8'h0C;
    localparam logic [7:0]  A_SPIRF = 8'h10;
    localparam int unsigned PMAX    = 4;

    logic        S_SYSCLK = 1'b0;
    logic        S_RESETN;
    logic        REQ_VALID, REQ_READY, REQ_RXEN;
    logic [31:0] REQ_SPCOM, REQ_TXDATA;
    logic        RSP_VALID, RSP_READY, RSP_ERR;
    logic [31:0] RSP_RXDATA;
    logic [7:0]  M_AWADDR, M_ARADDR;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [31:0] M_WDATA, M_RDATA;
    logic [3:0]  M_WSTRB;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [1:0]  M_RRESP;

    spi_xfer_sequencer #(
        .ADDR_SPIE (A_SPIE),
        .ADDR_SPCOM(A_SPCOM),
        .ADDR_SPITF(A_SPITF),
        .ADDR_SPIRF(A_SPIRF),
        .POLL_MAX  (PMAX)
    ) dut (
        .S_SYSCLK  (S_SYSCLK),
        .S_RESETN  (S_RESETN),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_SPCOM (REQ_SPCOM),
        .REQ_TXDATA(REQ_TXDATA),
        .REQ_RXEN  (REQ_RXEN),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RXDATA(RSP_RXDATA),
        .RSP_ERR   (RSP_ERR),
        .M_AWADDR  (M_AWADDR),
        .M_AWVALID (M_AWVALID),
        .M_AWREADY (M_AWREADY),
        .M_WDATA   (M_WDATA),
        .M_WSTRB   (M_WSTRB),
        .M_WVALID  (M_WVALID),
        .M_WREADY  (M_WREADY),
        .M_BVALID  (M_BVALID),
        .M_BREADY  (M_BREADY),
        .M_ARADDR  (M_ARADDR),
        .M_ARVALID (M_ARVALID),
        .M_ARREADY (M_ARREADY),
        .M_RDATA   (M_RDATA),
        .M_RRESP   (M_RRESP),
        .M_RVALID  (M_RVALID),
        .M_RREADY  (M_RREADY)
    );

    always #5 S_SYSCLK = ~S_SYSCLK;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] aw_hi;
        logic [31:0] w_hi;
        logic        moved;
    } wr_t;

    wr_t        exp_wr[$], obs_wr[$];
    logic [7:0] exp_rd[$], obs_rd[$];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Controller model configuration (written by the stimulus process only).
    int unsigned cfg_aw_stall   = 0;
    int unsigned cfg_don_at     = 1;
    logic [31:0] cfg_spirf_data = '0;
    logic [1:0]  cfg_spirf_resp = 2'b00;

    // Controller model state (written by the model process only).
    wr_t         cur;
    logic        aw_got, w_got, ar_got, b_hs, r_hs;
    logic [7:0]  rd_addr;
    int unsigned spie_rd;
    int unsigned n_both = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_ARREADY = 1'b0;
        M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
        cur = '0; aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
        rd_addr = '0; spie_rd = 0;
        forever begin
            @(negedge S_SYSCLK);
            if (!S_RESETN) begin
                M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_ARREADY = 1'b0;
                M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
                cur = '0; aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
                b_hs = 1'b0; r_hs = 1'b0; spie_rd = 0;
            end else begin
                if (b_hs) begin M_BVALID = 1'b0; b_hs = 1'b0; end
                if (r_hs) begin M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00; r_hs = 1'b0; end
                if (M_AWVALID && M_ARVALID) n_both++;
                if (aw_got && w_got && !M_BVALID) M_BVALID = 1'b1;
                if (M_BVALID && M_BREADY) begin
                    b_hs = 1'b1;
                    obs_wr.push_back(cur);
                    if (cur.addr == A_SPIE) spie_rd = 0;
                    cur = '0; aw_got = 1'b0; w_got = 1'b0;
                end
                M_AWREADY = 1'b0;
                if (M_AWVALID) begin
                    if (cur.aw_hi == 0) cur.addr = M_AWADDR;
                    else if (M_AWADDR !== cur.addr) cur.moved = 1'b1;
                    cur.aw_hi = cur.aw_hi + 1;
                    if (!aw_got && cur.aw_hi > cfg_aw_stall) begin M_AWREADY = 1'b1; aw_got = 1'b1; end
                end
                M_WREADY = 1'b0;
                if (M_WVALID) begin
                    cur.w_hi = cur.w_hi + 1;
                    if (!w_got) begin
                        cur.data = M_WDATA; cur.strb = M_WSTRB;
                        M_WREADY = 1'b1; w_got = 1'b1;
                    end
                end
                if (ar_got && !M_RVALID) begin
                    M_RVALID = 1'b1;
                    if (rd_addr == A_SPIE) begin
                        spie_rd++;
                        M_RDATA = (spie_rd == cfg_don_at) ? 32'h0000_0100 : 32'h0000_00FF;
                        M_RRESP = 2'b00;
                    end else begin
                        M_RDATA = cfg_spirf_data;
                        M_RRESP = cfg_spirf_resp;
                    end
                    ar_got = 1'b0;
                end
                if (M_RVALID && M_RREADY) r_hs = 1'b1;
                M_ARREADY = 1'b0;
                if (M_ARVALID && !ar_got && !M_RVALID) begin
                    M_ARREADY = 1'b1; ar_got = 1'b1;
                    rd_addr = M_ARADDR;
                    obs_rd.push_back(M_ARADDR);
                end
            end
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d, input int unsigned stall);
        wr_t e;
        e = '0;
        e.addr = a; e.data = d; e.strb = 4'hF;
        e.aw_hi = stall + 1; e.w_hi = 1; e.moved = 1'b0;
        exp_wr.push_back(e);
    endtask

    task automatic drain_scoreboard(input string tag);
        wr_t e, o;
        logic [7:0] ea;
        int unsigned k = 0;
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk($sformatf("%s_wr%0d_present", tag, k), 32'(obs_wr.size() != 0), 1);
            if (obs_wr.size() != 0) begin
                o = obs_wr.pop_front();
                chk($sformatf("%s_wr%0d_addr", tag, k), 32'(o.addr), 32'(e.addr));
                chk($sformatf("%s_wr%0d_data", tag, k), o.data, e.data);
                chk($sformatf("%s_wr%0d_strb", tag, k), 32'(o.strb), 32'(e.strb));
                chk($sformatf("%s_wr%0d_awvalid_cycles", tag, k), o.aw_hi, e.aw_hi);
                chk($sformatf("%s_wr%0d_wvalid_cycles", tag, k), o.w_hi, e.w_hi);
                chk($sformatf("%s_wr%0d_addr_moved", tag, k), 32'(o.moved), 0);
            end
            k++;
        end
        chk($sformatf("%s_extra_writes", tag), obs_wr.size(), 0);
        k = 0;
        while (exp_rd.size() != 0) begin
            ea = exp_rd.pop_front();
            chk($sformatf("%s_rd%0d_present", tag, k), 32'(obs_rd.size() != 0), 1);
            if (obs_rd.size() != 0) chk($sformatf("%s_rd%0d_addr", tag, k), 32'(obs_rd.pop_front()), 32'(ea));
            k++;
        end
        chk($sformatf("%s_extra_reads", tag), obs_rd.size(), 0);
        chk($sformatf("%s_aw_ar_overlap", tag), n_both, 0);
    endtask

    task automatic send_req(input string tag, input logic [31:0] spcom, input logic [31:0] tx,
                            input logic rxen);
        logic acc;
        REQ_SPCOM = spcom; REQ_TXDATA = tx; REQ_RXEN = rxen; REQ_VALID = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (REQ_READY) acc = 1'b1;
            @(negedge S_SYSCLK);
        end
        REQ_VALID = 1'b0;
        chk({tag, "_accept"}, 32'(acc), 1);
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] spcom, input logic [31:0] tx,
                            input logic rxen, input int unsigned don_at, input logic [31:0] spirf,
                            input logic [1:0] rresp, input int unsigned aw_stall,
                            input int unsigned rsp_delay);
        logic        don_ok, rf_rd, e_err, e0, stable;
        logic [31:0] e_rx, d0;
        int unsigned n_spie, hi;
        cfg_aw_stall = aw_stall; cfg_don_at = don_at;
        cfg_spirf_data = spirf; cfg_spirf_resp = rresp;
        don_ok = (don_at != 0) && (don_at <= PMAX);
        n_spie = don_ok ? don_at : PMAX;
        rf_rd  = don_ok && rxen;
        e_err  = !don_ok || (rf_rd && rresp != 2'b00);
        e_rx   = rf_rd ? spirf : 32'h0;
        push_wr(A_SPIE, 32'hFFFF_FFFF, aw_stall);
        push_wr(A_SPCOM, spcom, aw_stall);
        push_wr(A_SPITF, tx, aw_stall);
        for (int unsigned i = 0; i < n_spie; i++) exp_rd.push_back(A_SPIE);
        if (rf_rd) exp_rd.push_back(A_SPIRF);

        send_req(tag, spcom, tx, rxen);
        for (int i = 0; i < 400 && !RSP_VALID; i++) @(negedge S_SYSCLK);
        chk({tag, "_rsp_arrived"}, 32'(RSP_VALID), 1);
        d0 = RSP_RXDATA; e0 = RSP_ERR; hi = 0; stable = 1'b1;
        for (int i = 0; i < 50 && RSP_VALID; i++) begin
            hi++;
            if (RSP_RXDATA !== d0 || RSP_ERR !== e0) stable = 1'b0;
            RSP_READY = (hi > rsp_delay);
            @(negedge S_SYSCLK);
        end
        RSP_READY = 1'b0;
        chk({tag, "_req_ready_after_rsp"}, 32'(REQ_READY), 1);
        chk({tag, "_rsp_rxdata"}, d0, e_rx);
        chk({tag, "_rsp_err"}, 32'(e0), 32'(e_err));
        chk({tag, "_rsp_valid_cycles"}, hi, rsp_delay + 1);
        chk({tag, "_rsp_stable"}, 32'(stable), 1);
        drain_scoreboard(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        S_RESETN = 1'b0; REQ_VALID = 1'b0; REQ_SPCOM = '0; REQ_TXDATA = '0;
        REQ_RXEN = 1'b0; RSP_READY = 1'b0;
        repeat (3) @(negedge S_SYSCLK);
        chk("rst_req_ready", 32'(REQ_READY), 1);
        chk("rst_awvalid", 32'(M_AWVALID), 0);
        chk("rst_wvalid", 32'(M_WVALID), 0);
        chk("rst_bready", 32'(M_BREADY), 0);
        chk("rst_arvalid", 32'(M_ARVALID), 0);
        chk("rst_rready", 32'(M_RREADY), 0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 0);
        chk("rst_rsp_err", 32'(RSP_ERR), 0);
        chk("rst_rsp_rxdata", RSP_RXDATA, 0);
        chk("rst_wstrb", 32'(M_WSTRB), 0);
        #2 S_RESETN = 1'b1;
        @(negedge S_SYSCLK);

        run_xfer("basic", 32'h0000_0006, 32'h0403_0201, 1'b1, 3, 32'h1122_3344, 2'b00, 0, 0);
        run_xfer("norx", 32'h0001_0008, 32'hA5A5_5A5A, 1'b0, 1, 32'hDEAD_BEEF, 2'b00, 0, 0);
        run_xfer("timeout", 32'h0000_0020, 32'h0000_00FF, 1'b1, 0, 32'h1357_9BDF, 2'b00, 0, 0);
        run_xfer("awstall", 32'h0000_0004, 32'h89AB_CDEF, 1'b1, 2, 32'h0BAD_F00D, 2'b00, 3, 0);
        run_xfer("rresp", 32'h0000_0002, 32'h0000_0055, 1'b1, 1, 32'h5566_7788, 2'b10, 0, 5);

        // Abandon a transfer mid-poll, then confirm the next one starts cleanly.
        cfg_aw_stall = 0; cfg_don_at = 0;
        send_req("abort", 32'h0000_0003, 32'h0000_0077, 1'b1);
        for (int i = 0; i < 100 && obs_rd.size() < 2; i++) @(negedge S_SYSCLK);
        chk("abort_poll_reached", 32'(obs_rd.size() >= 2), 1);
        #2 S_RESETN = 1'b0;
        #1;
        chk("abort_awvalid", 32'(M_AWVALID), 0);
        chk("abort_wvalid", 32'(M_WVALID), 0);
        chk("abort_bready", 32'(M_BREADY), 0);
        chk("abort_arvalid", 32'(M_ARVALID), 0);
        chk("abort_rready", 32'(M_RREADY), 0);
        chk("abort_araddr", 32'(M_ARADDR), 0);
        chk("abort_rsp_valid", 32'(RSP_VALID), 0);
        chk("abort_req_ready", 32'(REQ_READY), 1);
        repeat (2) @(negedge S_SYSCLK);
        exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
        #2 S_RESETN = 1'b1;
        @(negedge S_SYSCLK);

        run_xfer("after_rst", 32'h0000_0010, 32'hCAFE_0001, 1'b1, PMAX, 32'h7654_3210, 2'b00, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
